// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the dual-clock FIFO.
// Used by both the read-side and write-side controllers.
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend in
    // and truncate out, so one function serves every AW.
    localparam int PTR_MAXW = 32;

    typedef logic [PTR_MAXW-1:0] ptr_max_t;

    // Output-register state for first-word-fall-through reads.
    typedef enum logic {
        FWFT_IDLE = 1'b0,
        FWFT_HOLD = 1'b1
    } fwft_state_t;

    // Memory depth for a given address width.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits of a zero-extended code leave the
    // prefix-XOR unchanged, so the full-width scan is exact.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clocks.
// Ports: I_CLK, I_RST_N (async low), I_D in, O_Q = I_D delayed.
module fifo_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         I_CLK,
    input  logic         I_RST_N,
    input  logic [W-1:0] I_D,
    output logic [W-1:0] O_Q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= I_D;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign O_Q = chain[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (read clock domain).
// Ports: I_RD_CLK/I_RD_RST_N; I_RD_EN read/pop-ack; I_RD_WR_PTR
// Gray write ptr (async); I_RD_MEM_DATA array data at O_RD_ADDR;
// I_RD_AE_THRESH, I_RD_CLR_UFLOW; outputs O_RD_ADDR, O_RD_PTR
// (Gray), O_RD_DATA/O_RD_VALID, O_RD_EMPTY, O_RD_AEMPTY,
// O_RD_LEVEL, O_RD_UFLOW (sticky).
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0
) (
    input  logic          I_RD_CLK,
    input  logic          I_RD_RST_N,
    input  logic          I_RD_EN,
    input  logic [AW:0]   I_RD_WR_PTR,
    input  logic [DW-1:0] I_RD_MEM_DATA,
    input  logic [AW:0]   I_RD_AE_THRESH,
    input  logic          I_RD_CLR_UFLOW,
    output logic [AW-1:0] O_RD_ADDR,
    output logic [AW:0]   O_RD_PTR,
    output logic [DW-1:0] O_RD_DATA,
    output logic          O_RD_VALID,
    output logic          O_RD_EMPTY,
    output logic          O_RD_AEMPTY,
    output logic [AW:0]   O_RD_LEVEL,
    output logic          O_RD_UFLOW
);

    localparam int PW = AW + 1;

    logic [PW-1:0] wr_sync;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_q;
    logic [PW-1:0] level_next;
    logic [PW-1:0] level_q;
    logic [DW-1:0] data_q;
    fwft_state_t   state_q;
    logic          mem_empty_q;
    logic          mem_empty_next;
    logic          aempty_q;
    logic          uflow_q;
    logic          valid;
    logic          pop;
    logic          uflow_set;

    fifo_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .I_CLK   (I_RD_CLK),
        .I_RST_N (I_RD_RST_N),
        .I_D     (I_RD_WR_PTR),
        .O_Q     (wr_sync)
    );

    assign wr_bin = PW'(gray2bin(ptr_max_t'(wr_sync)));
    assign valid  = (state_q == FWFT_HOLD);

    // In FWFT the output register refills itself whenever it is
    // free or being drained; in standard mode only on request.
    always_comb begin
        pop       = 1'b0;
        uflow_set = 1'b0;
        if (FWFT != 0) begin
            pop       = ~mem_empty_q & (~valid | I_RD_EN);
            uflow_set = I_RD_EN & ~valid;
        end else begin
            pop       = I_RD_EN & ~mem_empty_q;
            uflow_set = I_RD_EN & mem_empty_q;
        end
    end

    assign rd_bin_next = rd_bin + PW'(pop);
    assign level_next  = wr_bin - rd_bin_next;
    assign mem_empty_next =
        (PW'(bin2gray(ptr_max_t'(rd_bin_next))) == wr_sync);

    always_ff @(posedge I_RD_CLK or negedge I_RD_RST_N) begin
        if (!I_RD_RST_N) begin
            rd_bin      <= '0;
            rd_gray_q   <= '0;
            data_q      <= '0;
            state_q     <= FWFT_IDLE;
            mem_empty_q <= 1'b1;
            aempty_q    <= 1'b1;
            level_q     <= '0;
            uflow_q     <= 1'b0;
        end else begin
            rd_bin      <= rd_bin_next;
            rd_gray_q   <= PW'(bin2gray(ptr_max_t'(rd_bin_next)));
            mem_empty_q <= mem_empty_next;
            level_q     <= level_next;
            aempty_q    <= (level_next <= I_RD_AE_THRESH);
            // A set wins over a simultaneous clear.
            uflow_q     <= uflow_set | (uflow_q & ~I_RD_CLR_UFLOW);
            if (pop) begin
                data_q <= I_RD_MEM_DATA;
            end
            if (FWFT != 0) begin
                unique case (state_q)
                    FWFT_IDLE: begin
                        if (pop) state_q <= FWFT_HOLD;
                    end
                    FWFT_HOLD: begin
                        if (I_RD_EN && !pop) state_q <= FWFT_IDLE;
                    end
                endcase
            end else begin
                // Standard mode: valid is a one-cycle pulse.
                state_q <= pop ? FWFT_HOLD : FWFT_IDLE;
            end
        end
    end

    assign O_RD_ADDR   = rd_bin[AW-1:0];
    assign O_RD_PTR    = rd_gray_q;
    assign O_RD_DATA   = data_q;
    assign O_RD_VALID  = valid;
    assign O_RD_EMPTY  = (FWFT != 0) ? ~valid : mem_empty_q;
    assign O_RD_AEMPTY = aempty_q;
    assign O_RD_LEVEL  = level_q;
    assign O_RD_UFLOW  = uflow_q;

endmodule
